uart_rx_buffered: RTL

- UART receiver with a receive FIFO. It sits between the SOC's `rx` pin and the SOC bus/UART register block.
- It deserialises 8N1 frames from `rx` and queues the received bytes in a show-ahead FIFO of UART_BUFFER_SIZE entries.
- The bus side pops bytes with `read_en`.
- Line errors are reported through sticky flags.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/uart_rx_buffered.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states, frame width and
// the bit-period helper used to size the baud counters.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_state_e;

    function automatic int clks_per_bit(input int freq, input int rate);
        return freq / rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy count. A push that
// finds the FIFO full (and no simultaneous pop) is dropped and flagged.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     push_rejected
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // A pop on the same edge frees a slot, so a push into a full FIFO is
    // still accepted when it coincides with a pop.
    always_comb begin
        do_pop        = pop && (count_q != '0);
        do_push       = push && ((count_q != CNT_FULL) || do_pop);
        push_rejected = push && !do_push;
        wr_ptr_d      = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d      = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d       = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

    assign data_out = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign count    = count_q;

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver feeding a show-ahead receive FIFO with sticky line-error
// flags. Define UART_RX_PARITY_EN to add an even-parity bit after the data.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ       = 25000000,
    parameter int BIT_RATE         = 115200,
    parameter int UART_BUFFER_SIZE = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                rx,
    input  logic                                read_en,
    input  logic                                clear_errors,
    output logic [7:0]                          data_out,
    output logic                                empty,
    output logic                                full,
    output logic [$clog2(UART_BUFFER_SIZE):0]   count,
    output logic                                overrun,
    output logic                                frame_error,
    output logic                                parity_error
);

    localparam int CPB   = clks_per_bit(CLOCK_FREQ, BIT_RATE);
    localparam int CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    uart_state_e          state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_error_q, frame_error_d;
    logic                 overrun_q, overrun_d;
    logic                 push, frame_set, parity_set, parity_bad_d, drop_byte;
    logic                 push_rejected;

    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = (baud_cnt_q == CNT_LAST) ? '0 : baud_cnt_q + CNT_ONE;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        push         = 1'b0;
        frame_set    = 1'b0;
        parity_set   = 1'b0;
        parity_bad_d = drop_byte;
        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (baud_cnt_q == CNT_HALF) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                // Counter wraps at CNT_LAST, so each sample lands one full
                // bit period after the previous one (first: mid-start).
                if (baud_cnt_q == CNT_LAST) begin
                    shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_cnt_q == CNT_LAST) begin
                    parity_bad_d = ^{shift_q, rx_s_q};
                    parity_set   = parity_bad_d;
                    state_d      = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_cnt_q == CNT_LAST) begin
                    if (rx_s_q) begin
                        push    = !drop_byte;
                        state_d = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // Hold off while the line is in break so it is not decoded
                // as a stream of 0x00 frames.
                baud_cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: begin
                baud_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase

        frame_error_d = (frame_error_q && !clear_errors) || frame_set;
        overrun_d     = (overrun_q && !clear_errors) || push_rejected;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            state_q       <= IDLE;
            baud_cnt_q    <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            rx_meta_q     <= rx;
            rx_s_q        <= rx_meta_q;
            state_q       <= state_d;
            baud_cnt_q    <= baud_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bad_q, parity_error_q, parity_error_d;

    assign parity_error_d = (parity_error_q && !clear_errors) || parity_set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_bad_q   <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            parity_bad_q   <= parity_bad_d;
            parity_error_q <= parity_error_d;
        end
    end

    assign drop_byte    = parity_bad_q;
    assign parity_error = parity_error_q;
`else
    assign drop_byte    = 1'b0;
    assign parity_error = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (UART_BUFFER_SIZE)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (reset),
        .push          (push),
        .push_data     (shift_q),
        .pop           (read_en),
        .data_out      (data_out),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .push_rejected (push_rejected)
    );

    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule
